cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Blocking write-through cache controller between CPU load/store port and main memory; drives cache_memory.
//  Splits CPU address into tag/set, checks hit, refills from memory on read miss, forwards all writes to memory.
//  One request outstanding at a time; cache_memory is instantiated by the parent alongside this block.
// PARAMETERS
//  ADDR_SIZE   32  byte-address width
//  NUM_SETS    4   sets in cache_memory (power of 2)
//  NUM_WAYS    2   ways in cache_memory (power of 2)
//  BLOCK_SIZE  32  block width in bits; one word per block, full-word accesses only
//  Derived: SetSize=$clog2(NUM_SETS), WaySize=$clog2(NUM_WAYS), TagSize=ADDR_SIZE-SetSize-2
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          reset, asynchronous, active-high
//  cpu_req_valid  in   1          CPU request present
//  cpu_req_ready  out  1          controller accepts request (IDLE only)
//  cpu_req_write  in   1          1=store, 0=load
//  cpu_addr       in   ADDR_SIZE  byte address; bits[1:0] ignored
//  cpu_wdata      in   32         store data
//  cpu_resp_valid out  1          one-cycle pulse: access complete
//  cpu_rdata      out  32         load data, valid with cpu_resp_valid
//  mem_req_valid  out  1          memory request, held until mem_req_ready
//  mem_req_ready  in   1          memory accepts request
//  mem_req_write  out  1          1=write, 0=read
//  mem_addr       out  ADDR_SIZE  word-aligned address (bits[1:0]=0)
//  mem_wdata      out  32         write data
//  mem_resp_valid in   1          read data / write ack, one cycle
//  mem_rdata      in   32         read data
//  cm_set         out  SetSize    set index to cache_memory
//  cm_tag         out  TagSize    tag to cache_memory
//  cm_write_enable out 1          cache_memory write strobe
//  cm_write_way   out  WaySize    way written
//  cm_write_data  out  32         data written
//  cm_read_data   in   32         combinational hit data
//  cm_hit         in   1          combinational hit
//  cm_hit_way     in   WaySize    way that hit (cache_memory hit_way port)
//  cm_populate_way in  WaySize    victim way chosen by cache_memory
//  perf_hits      out  32         hit counter, saturates at 2^32-1
//  perf_misses    out  32         miss counter, saturates at 2^32-1
// BEHAVIOUR
//  Reset: state=IDLE; cpu_resp_valid, mem_req_valid, cm_write_enable=0; perf counters=0; cpu_rdata=0; cpu_req_ready=1.
//  Request accepted on cpu_req_valid&&cpu_req_ready; addr/wdata/write latched; cm_set/cm_tag driven from latch.
//  States: IDLE -> COMPARE -> {DONE | MEM_REQ -> MEM_WAIT -> (REFILL) -> DONE} -> IDLE.
//  COMPARE read hit: cpu_rdata<=cm_read_data, perf_hits++, -> DONE. Hit response 2 cycles after accept.
//  COMPARE read miss: perf_misses++, -> MEM_REQ (mem_req_write=0).
//  COMPARE write: hit -> cm_write_enable=1, cm_write_way=cm_hit_way, data=latched wdata, perf_hits++;
//    miss -> no cache write (no-write-allocate), perf_misses++; both -> MEM_REQ (mem_req_write=1).
//  MEM_REQ: mem_req_valid=1 with stable addr/wdata/write until mem_req_ready; -> MEM_WAIT.
//  MEM_WAIT: wait mem_resp_valid; read -> capture mem_rdata into cpu_rdata, -> REFILL; write -> DONE.
//  REFILL: cm_write_enable=1, cm_write_way=cm_populate_way (sampled this cycle), cm_write_data=captured word; -> DONE.
//  DONE: cpu_resp_valid=1 for exactly one cycle; cpu_rdata held until next response; -> IDLE.
//  mem_resp_valid outside MEM_WAIT ignored (incl. in same cycle as mem_req_ready); unbounded memory latency allowed.
//  cpu_req_ready=0 outside IDLE; no request queuing.
//  Counters: saturate, never wrap; simultaneous increment impossible (one event per access).
//  Reset mid-miss: immediate return to IDLE, mem_req_valid dropped, no cache write; late response ignored.
// STRUCTURE
//  cache_pkg: ctrl_state_e enum (IDLE,COMPARE,MEM_REQ,MEM_WAIT,REFILL,DONE); addr split helper functions
//    (get_set, get_tag) parameterised by ADDR_SIZE/NUM_SETS; shared with cache_memory.
//  Single module, no sub-module: one FSM, request latch, two saturating counters.
// TESTING
//  Read miss 0x0000_1040, mem returns 0xDEAD_BEEF after 3 cycles -> mem read addr 0x1040, cache write way=populate_way,
//    cpu_rdata=0xDEAD_BEEF, perf_misses=1.
//  Repeat read 0x1040 -> no mem_req_valid, cpu_resp_valid 2 cycles after accept, cpu_rdata=0xDEAD_BEEF, perf_hits=1.
//  Write 0x1040=0x1234_5678 (hit) -> cache write way=hit_way, mem write 0x1040; re-read returns 0x1234_5678 from cache.
//  Write miss 0x2000=0xCAFE_F00D -> mem write only, no cm_write_enable; read 0x2000 -> miss and refill.
//  mem_req_ready held low 5 cycles -> mem_req_valid, mem_addr, mem_wdata stable throughout; cpu_req_ready=0.
//  Assert rst in MEM_WAIT, pulse mem_resp_valid afterwards -> IDLE, counters=0, no cm write, no cpu_resp_valid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and cache_memory.
// Holds the controller state encoding and the address split helpers.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MEM_REQ,
        MEM_WAIT,
        REFILL,
        DONE
    } ctrl_state_e;

    localparam int unsigned MAX_ADDR_SIZE = 64;

    typedef logic [MAX_ADDR_SIZE-1:0] wide_addr_t;

    // Word index modulo the set count; num_sets must be a power of two.
    function automatic wide_addr_t get_set(input wide_addr_t addr, input int unsigned num_sets);
        return (addr >> 2) & (wide_addr_t'(num_sets) - wide_addr_t'(1));
    endfunction

    function automatic wide_addr_t get_tag(input wide_addr_t addr, input int unsigned addr_size,
                                           input int unsigned num_sets);
        wide_addr_t mask;
        mask = (addr_size >= MAX_ADDR_SIZE) ? '1 : ((wide_addr_t'(1) << addr_size) - wide_addr_t'(1));
        return (addr & mask) >> (2 + $clog2(num_sets));
    endfunction

endpackage

// File: rtl/cache_controller.sv
// Blocking write-through, no-write-allocate cache controller.
// One request in flight; cache_memory is a sibling driven through the cm_* ports.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned NUM_SETS   = 4,
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned BLOCK_SIZE = 32,
    localparam int unsigned SetSize   = $clog2(NUM_SETS),
    localparam int unsigned WaySize   = $clog2(NUM_WAYS),
    localparam int unsigned TagSize   = ADDR_SIZE - SetSize - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [ADDR_SIZE-1:0]  cpu_addr,
    input  logic [BLOCK_SIZE-1:0] cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [BLOCK_SIZE-1:0] cpu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [BLOCK_SIZE-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    output logic [SetSize-1:0]    cm_set,
    output logic [TagSize-1:0]    cm_tag,
    output logic                  cm_write_enable,
    output logic [WaySize-1:0]    cm_write_way,
    output logic [BLOCK_SIZE-1:0] cm_write_data,
    input  logic [BLOCK_SIZE-1:0] cm_read_data,
    input  logic                  cm_hit,
    input  logic [WaySize-1:0]    cm_hit_way,
    input  logic [WaySize-1:0]    cm_populate_way,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_misses
);

    ctrl_state_e state, next_state;

    logic [ADDR_SIZE-3:0]  word_addr_q;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic                  write_q;
    logic [ADDR_SIZE-1:0]  byte_addr;

    assign byte_addr     = {word_addr_q, 2'b00};
    assign mem_addr      = byte_addr;
    assign mem_wdata     = wdata_q;
    assign mem_req_write = write_q;
    assign cm_set        = SetSize'(get_set(MAX_ADDR_SIZE'(byte_addr), NUM_SETS));
    assign cm_tag        = TagSize'(get_tag(MAX_ADDR_SIZE'(byte_addr), ADDR_SIZE, NUM_SETS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_addr_q <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cpu_rdata   <= '0;
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && cpu_req_valid) begin
                word_addr_q <= cpu_addr[ADDR_SIZE-1:2];
                wdata_q     <= cpu_wdata;
                write_q     <= cpu_req_write;
            end
            if (state == COMPARE) begin
                if (cm_hit) begin
                    if (!write_q) cpu_rdata <= cm_read_data;
                    if (perf_hits != '1) perf_hits <= perf_hits + 32'd1;
                end else if (perf_misses != '1) begin
                    perf_misses <= perf_misses + 32'd1;
                end
            end
            // cpu_rdata doubles as the refill buffer written to the cache in REFILL
            if (state == MEM_WAIT && mem_resp_valid && !write_q) cpu_rdata <= mem_rdata;
        end
    end

    always_comb begin
        next_state      = state;
        cpu_req_ready   = 1'b0;
        cpu_resp_valid  = 1'b0;
        mem_req_valid   = 1'b0;
        cm_write_enable = 1'b0;
        cm_write_way    = cm_populate_way;
        cm_write_data   = cpu_rdata;
        unique case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) next_state = COMPARE;
            end
            COMPARE: begin
                if (write_q) begin
                    if (cm_hit) begin
                        cm_write_enable = 1'b1;
                        cm_write_way    = cm_hit_way;
                        cm_write_data   = wdata_q;
                    end
                    next_state = MEM_REQ;
                end else begin
                    next_state = cm_hit ? DONE : MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) next_state = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_resp_valid) next_state = write_q ? DONE : REFILL;
            end
            REFILL: begin
                cm_write_enable = 1'b1;
                next_state      = DONE;
            end
            DONE: begin
                cpu_resp_valid = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed plus random bench for cache_controller with a cache_memory stand-in,
// a memory responder and an address-level reference of cache residency and memory contents.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_resp_valid;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_resp_valid;
    logic [1:0]  cm_set;
    logic [27:0] cm_tag;
    logic        cm_write_enable;
    logic [0:0]  cm_write_way, cm_hit_way, cm_populate_way;
    logic [31:0] cm_write_data, cm_read_data;
    logic        cm_hit;
    logic [31:0] perf_hits, perf_misses;

    always #5 clk = ~clk;

    cache_controller #(.ADDR_SIZE(32), .NUM_SETS(4), .NUM_WAYS(2), .BLOCK_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_write(cpu_req_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .cm_set(cm_set), .cm_tag(cm_tag), .cm_write_enable(cm_write_enable), .cm_write_way(cm_write_way),
        .cm_write_data(cm_write_data), .cm_read_data(cm_read_data), .cm_hit(cm_hit), .cm_hit_way(cm_hit_way),
        .cm_populate_way(cm_populate_way), .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    // cache_memory stand-in: storage follows whatever the DUT writes
    logic [27:0] ct [4][2];
    logic [31:0] cd [4][2];
    logic        cv [4][2] = '{default: 1'b0};

    always_comb begin
        cm_hit       = 1'b0;
        cm_hit_way   = 1'b0;
        cm_read_data = '0;
        for (int w = 0; w < 2; w++) begin
            if (cv[cm_set][w] && ct[cm_set][w] == cm_tag) begin
                cm_hit       = 1'b1;
                cm_hit_way   = 1'(w);
                cm_read_data = cd[cm_set][w];
            end
        end
    end

    always @(posedge clk) begin
        if (cm_write_enable) begin
            cv[cm_set][cm_write_way] <= 1'b1;
            ct[cm_set][cm_write_way] <= cm_tag;
            cd[cm_set][cm_write_way] <= cm_write_data;
        end
    end

    // reference: which word address sits in each set/way, and memory contents
    logic [29:0] rword [4][2];
    bit          rvalid [4][2];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] mem_dev [logic [29:0]];
    int unsigned exp_hits = 0, exp_misses = 0;
    int unsigned checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic seed(input logic [29:0] word, input logic [31:0] val);
        if (!ref_mem.exists(word)) begin
            ref_mem[word] = val;
            mem_dev[word] = val;
        end
    endtask

    // Entered and left on a falling edge with the DUT idle.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int unsigned lat, input int unsigned rdy_dly, input string tag);
        logic [29:0] word;
        int unsigned s, mphase, mcnt, lcnt, n_cmw, resp_cyc;
        bit          hit, done, saw_mem;
        logic [0:0]  hway, pop, cmw_way;
        logic [31:0] m_addr, m_wdata, cmw_data, got_rdata;
        logic        m_write;
        word = addr[31:2];
        s = 32'(word % 30'd4);
        seed(word, $urandom);
        hit = 1'b0; hway = 1'b0;
        for (int w = 0; w < 2; w++)
            if (rvalid[s][w] && rword[s][w] == word) begin hit = 1'b1; hway = 1'(w); end
        pop = 1'($urandom_range(0, 1));
        cm_populate_way = pop;
        mphase = 0; mcnt = 0; lcnt = 0; n_cmw = 0; resp_cyc = 0;
        done = 1'b0; saw_mem = 1'b0;
        m_addr = 'x; m_wdata = 'x; m_write = 1'bx; cmw_way = 'x; cmw_data = 'x; got_rdata = 'x;

        chk({tag, "_ready_idle"}, cpu_req_ready, 1);
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_write = ~wr; cpu_addr = $urandom; cpu_wdata = $urandom;

        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = $urandom;
            chk({tag, "_ready_busy"}, cpu_req_ready, 0);
            if (cm_write_enable) begin n_cmw++; cmw_way = cm_write_way; cmw_data = cm_write_data; end
            if (mphase == 0 && mem_req_valid) begin
                saw_mem = 1'b1; m_addr = mem_addr; m_wdata = mem_wdata; m_write = mem_req_write;
                mphase = 1;
            end
            if (mphase == 1) begin
                chk({tag, "_req_held"}, {mem_req_valid, mem_addr, mem_wdata, mem_req_write},
                    {1'b1, m_addr, m_wdata, m_write});
                if (mcnt == rdy_dly) begin
                    mem_req_ready = 1'b1;
                    mem_resp_valid = 1'b1;   // must be ignored while still requesting
                    mphase = 2;
                end else mcnt++;
            end else if (mphase == 2) begin
                chk({tag, "_req_dropped"}, mem_req_valid, 0);
                if (lcnt == lat) begin
                    mem_resp_valid = 1'b1;
                    if (m_write) mem_dev[m_addr[31:2]] = m_wdata;
                    else mem_rdata = mem_dev.exists(m_addr[31:2]) ? mem_dev[m_addr[31:2]] : 32'h0;
                    mphase = 3;
                end else lcnt++;
            end
            if (cpu_resp_valid) begin done = 1'b1; resp_cyc = cyc; got_rdata = cpu_rdata; end
            @(negedge clk);
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        chk({tag, "_resp_seen"}, done, 1);
        chk({tag, "_resp_one_cycle"}, cpu_resp_valid, 0);

        if (!wr) begin
            chk({tag, "_rdata"}, got_rdata, ref_mem[word]);
            if (hit) begin
                exp_hits++;
                chk({tag, "_hit_no_mem"}, saw_mem, 0);
                chk({tag, "_hit_latency"}, resp_cyc, 2);
                chk({tag, "_hit_no_cmw"}, n_cmw, 0);
            end else begin
                exp_misses++;
                chk({tag, "_miss_mem"}, {saw_mem, m_write, m_addr}, {1'b1, 1'b0, word, 2'b00});
                chk({tag, "_refill"}, {n_cmw, cmw_way, cmw_data}, {32'd1, pop, ref_mem[word]});
                rword[s][pop] = word;
                rvalid[s][pop] = 1'b1;
            end
        end else begin
            if (hit) exp_hits++; else exp_misses++;
            ref_mem[word] = wd;
            chk({tag, "_wr_mem"}, {saw_mem, m_write, m_addr, m_wdata}, {1'b1, 1'b1, word, 2'b00, wd});
            chk({tag, "_wr_cmw_count"}, n_cmw, hit ? 1 : 0);
            if (hit) chk({tag, "_wr_cmw"}, {cmw_way, cmw_data}, {hway, wd});
        end
        chk({tag, "_perf_hits"}, perf_hits, exp_hits);
        chk({tag, "_perf_misses"}, perf_misses, exp_misses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; cm_populate_way = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {cpu_req_ready, cpu_resp_valid, mem_req_valid, cm_write_enable},
            {1'b1, 1'b0, 1'b0, 1'b0});
        chk("reset_counters", {perf_hits, perf_misses, cpu_rdata}, '0);

        seed(30'h0000_1040 >> 2, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_1040, 32'h0, 3, 0, "rd_miss");
        access(1'b0, 32'h0000_1040, 32'h0, 0, 0, "rd_hit");
        access(1'b1, 32'h0000_1040, 32'h1234_5678, 1, 1, "wr_hit");
        access(1'b0, 32'h0000_1040, 32'h0, 0, 0, "rd_after_wr");
        access(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 2, 0, "wr_miss");
        access(1'b0, 32'h0000_2000, 32'h0, 1, 0, "rd_after_wr_miss");
        access(1'b0, 32'h0000_4000, 32'h0, 2, 5, "stall_rd");
        access(1'b1, 32'h0000_4004, 32'hA5A5_0F0F, 2, 5, "stall_wr");

        // reset while the miss is waiting on memory
        seed(30'h0000_5000 >> 2, 32'h0BAD_0BAD);
        cm_populate_way = 1'b1;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_addr = 32'h0000_5000;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req_valid) found = 1'b1; else @(negedge clk);
        end
        chk("rst_mid_reqseen", found, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rst_mid_inwait", {mem_req_valid, cpu_req_ready}, {1'b0, 1'b0});
        #2 rst = 1'b1;
        #1 chk("rst_async", {cpu_req_ready, mem_req_valid, cm_write_enable, cpu_resp_valid},
               {1'b1, 1'b0, 1'b0, 1'b0});
        chk("rst_counters", {perf_hits, perf_misses, cpu_rdata}, '0);
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0; exp_misses = 0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            chk("rst_late_resp", {cpu_resp_valid, cm_write_enable, mem_req_valid, cpu_req_ready},
                {1'b0, 1'b0, 1'b0, 1'b1});
        end

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = 32'h0000_3000 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 4),
                   $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
